// File: rtl/adc_pkg.sv
// adc_pkg: shared constants and types for the LTC2308 scan sequencer
package adc_pkg;
  localparam int NCH = 8;
  localparam int RES_W = 12;
  typedef logic [2:0] chan_t;
  typedef struct packed {
    logic  valid;
    chan_t chan;
    logic  is_req;
  } tag_t;
  typedef enum logic {IDLE, SCAN} state_t;
endpackage

// File: rtl/adc_rr_select.sv
// adc_rr_select: next set mask bit strictly after a given channel, wrapping
module adc_rr_select
  import adc_pkg::*;
(
  input  logic [NCH-1:0] mask,
  input  chan_t          after,
  output chan_t          next,
  output logic           none
);
  // Walk downwards so the nearest hit wins; the 3-bit sum wraps naturally
  always_comb begin
    next = '0;
    none = 1'b1;
    for (int i = NCH; i >= 1; i--) begin
      if (mask[after + chan_t'(i)]) begin
        next = after + chan_t'(i);
        none = 1'b0;
      end
    end
  end
endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: round-robin LTC2308 scan with averaging and priority single-shot requests
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [NCH-1:0]   chan_mask,
  input  logic             frame_done,
  input  logic [RES_W-1:0] adc_result,
  output logic [2:0]       adc_chan,
  input  logic             req,
  input  logic [2:0]       req_chan,
  output logic             req_ack,
  output logic [RES_W-1:0] req_data,
  input  logic [2:0]       rd_chan,
  output logic [RES_W-1:0] rd_data,
  output logic [NCH-1:0]   valid,
  output logic             sample_stb,
  output logic [2:0]       sample_chan
);
  localparam int AW = RES_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] CNT_LAST = (AVG_LOG2 + 1)'(2 ** AVG_LOG2 - 1);

  state_t state, state_nx;
  tag_t tag0, tag1, new_tag;
  chan_t last_scan, scan_chan;
  logic scan_none, issue_req, issue_scan, req_issued, enable_q;
  logic [AW-1:0] acc [NCH];
  logic [AVG_LOG2:0] cnt [NCH];
  logic [RES_W-1:0] bank [NCH];
  logic [AW-1:0] sum;

  adc_rr_select u_sel (
    .mask  (chan_mask),
    .after (last_scan),
    .next  (scan_chan),
    .none  (scan_none)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb state_nx = (enable && (chan_mask != '0 || req)) ? SCAN : IDLE;

  always_comb begin
    issue_req  = state == SCAN && req && !req_issued;
    issue_scan = state == SCAN && !issue_req && !scan_none;
    new_tag    = issue_req ? {1'b1, req_chan, 1'b1} : issue_scan ? {1'b1, scan_chan, 1'b0} : '0;
  end

  // The word arriving now belongs to the config sent one frame ago (tag1)
  assign sum     = acc[tag1.chan] + AW'(adc_result);
  assign rd_data = bank[rd_chan];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag0 <= '0;
      tag1 <= '0;
      adc_chan <= '0;
      req_ack <= 1'b0;
      req_data <= '0;
      valid <= '0;
      sample_stb <= 1'b0;
      sample_chan <= '0;
      last_scan <= chan_t'(NCH - 1);
      req_issued <= 1'b0;
      enable_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
        bank[i] <= '0;
      end
    end else begin
      enable_q <= enable;
      req_ack <= 1'b0;
      sample_stb <= 1'b0;
      if (enable && !enable_q) begin
        for (int i = 0; i < NCH; i++) begin
          acc[i] <= '0;
          cnt[i] <= '0;
        end
      end
      if (frame_done) begin
        tag1 <= tag0;
        tag0 <= new_tag;
        if (new_tag.valid) adc_chan <= new_tag.chan;
        if (issue_scan) last_scan <= scan_chan;
        if (tag1.valid && tag1.is_req) begin
          req_data <= adc_result;
          req_ack <= 1'b1;
          req_issued <= 1'b0;
        end else if (tag1.valid) begin
          if (cnt[tag1.chan] == CNT_LAST) begin
            bank[tag1.chan] <= RES_W'(sum >> AVG_LOG2);
            valid[tag1.chan] <= 1'b1;
            sample_stb <= 1'b1;
            sample_chan <= tag1.chan;
            acc[tag1.chan] <= '0;
            cnt[tag1.chan] <= '0;
          end else begin
            acc[tag1.chan] <= sum;
            cnt[tag1.chan] <= cnt[tag1.chan] + 1'b1;
          end
        end
        if (issue_req) req_issued <= 1'b1;
      end
    end
  end
endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Controller that sequences the LTC2308 serial ADC interface. It drives its 3-bit channel select and captures its 12-bit result once per conversion frame.
- Round-robin scans the enabled channels and averages 2^AVG_LOG2 samples per channel into a readable per-channel sample bank.
- Serves one on-demand single-shot requester that has priority over the scan.
- Sits between the ADC interface and the application logic (sensor/motor control), all in the ADC clock domain.

Parameters:
- NCH, 8, number of ADC channels (chan width = 3)
- AVG_LOG2, 2, log2 of samples averaged per stored value (0 = no averaging)
- RES_W, 12, ADC result width

Ports:
- clk  in  1  ADC interface clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  scan enable (level)
- chan_mask  in  NCH  enabled channels for scanning
- frame_done  in  1  one-clk pulse per ADC frame, asserted when adc_result holds the new word; precedes the next CONVST by at least 2 clk
- adc_result  in  RES_W  result word from the ADC interface
- adc_chan  out  3  channel select to the ADC interface
- req  in  1  on-demand conversion request (level, held until req_ack)
- req_chan  in  3  channel for the on-demand request, stable while req is high
- req_ack  out  1  one-clk pulse; req_data valid in the same cycle
- req_data  out  RES_W  raw (unaveraged) on-demand result
- rd_chan  in  3  sample-bank read address
- rd_data  out  RES_W  averaged sample for rd_chan (combinational read)
- valid  out  NCH  per-channel "sample bank holds a value" flags
- sample_stb  out  1  one-clk pulse when a bank entry is updated
- sample_chan  out  3  channel updated with sample_stb

Behaviour:
- Reset values: adc_chan=0, req_ack=0, req_data=0, valid=0, sample_stb=0, sample_chan=0, bank=0, accumulators=0, tags invalid, state IDLE.
- All updates happen only on frame_done cycles, except the combinational rd_data.
- Tag pipeline: two entries. tag0 is the channel/kind sent in the current frame. tag1 is the channel/kind sent in the previous frame. Each tag holds {valid, chan, is_req}.
  - Because the ADC applies the config from frame k to the conversion read out in frame k+1, the adc_result seen at frame_done belongs to tag1.
  - On each frame_done: process adc_result against tag1, then set tag1<=tag0, tag0<=new selection, adc_chan<=new selection.
- States:
  - IDLE: enable=0 or (chan_mask=0 and no req). Nothing is issued; new tags are invalid. Results for tags already in flight are still processed.
  - SCAN: otherwise.
- Selection at frame_done, in priority order:
  1. A pending req not yet issued issues req_chan (is_req=1). A request is issued exactly once.
  2. Otherwise, the next set bit of chan_mask strictly after the last scanned channel, wrapping 7->0. A single-bit mask reissues the same channel every frame.
  3. Otherwise, an invalid tag.
- Processing tag1:
  - Invalid tag: discard. The first 2 frames after reset or enable rise are always discarded.
  - is_req=1: req_data<=adc_result, req_ack pulses. The requester must drop req by the next clk. Latency is 2 frame_done pulses after issue.
  - Scan tag: acc[ch]+=adc_result (width RES_W+AVG_LOG2, cannot overflow) and cnt[ch]++.
    - When cnt[ch] reaches 2^AVG_LOG2: bank[ch]<=acc>>AVG_LOG2 (truncate), valid[ch]<=1, sample_stb=1, sample_chan=ch, then clear acc/cnt.
- chan_mask change mid-scan: takes effect at the next selection. Partial accumulations of de-selected channels are kept; valid and bank are unchanged.
- enable falling: no new scan issues. In-flight scan tags still complete. acc/cnt of all channels clear at the next enable rise; valid and bank are retained.
- Asynchronous reset mid-frame returns everything to reset values at once. No ack is generated for a request outstanding at reset.
- A simultaneous req assert and scan slot gives the request the slot. The scan resumes from where it left off, with no channel skipped.

Decomposition:
- Package adc_pkg: RES_W, NCH, chan_t (logic [2:0]), the tag struct {valid, chan, is_req}, state enum {IDLE, SCAN}.
- One sub-module: adc_rr_select. It is combinational and computes the next set bit of the mask after a given index with wrap, plus a none-found flag.

Test Plan:
- Reset, enable=1, mask=8'h05, AVG_LOG2=0, adc_result=chan*100 per tag1 -> adc_chan sequence 0,2,0,2. First 2 frames discarded. Bank[0]=0, bank[2]=200, valid=8'h05.
- AVG_LOG2=2, mask=8'h01, results 10,11,12,14 -> one sample_stb after the 4th processed frame, bank[0]=11 (47>>2). No strobe earlier.
- Scan running on mask=8'hFF; req with req_chan=5 while the next scan channel is 3 -> adc_chan=5 at the next frame, then 3. req_ack comes 2 frame_done later with req_data equal to that frame's adc_result. Channel-5 accumulator is unchanged.
- mask=8'h00, enable=1, no req -> IDLE, adc_chan held, no strobes. Then req for channel 7 -> ack after 2 frames.
- reset_n low mid-scan, with valid=8'h0F and an outstanding req -> all outputs at reset values at once, no req_ack. Scan restarts at channel 0 after release.
- Toggle chan_mask from 8'h03 to 8'h0C between frames -> the next issued channel is 2. In-flight channel-1 results are still accumulated.
